// File: rtl/error_monitor_pkg.sv
// Shared error codes, FSM states and violation priority encoder
// for the error monitor and the display handler.
package error_monitor_pkg;

  localparam logic [7:0] ERR_NONE       = 8'd0;
  localparam logic [7:0] ERR_LD_STACK   = 8'd1;
  localparam logic [7:0] ERR_ST_STACK   = 8'd2;
  localparam logic [7:0] ERR_PUSH_FULL  = 8'd3;
  localparam logic [7:0] ERR_POP_EMPTY  = 8'd4;
  localparam logic [7:0] ERR_RET_EMPTY  = 8'd5;
  localparam logic [7:0] ERR_CALL_FULL  = 8'd6;

  localparam logic [3:0] LOST_MAX = 4'hF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FAULT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Lowest code wins when several violations share a cycle.
  function automatic logic [7:0] viol_code(
    input logic in_rng,
    input logic ld,
    input logic st,
    input logic push,
    input logic pop,
    input logic call,
    input logic ret,
    input logic full,
    input logic empty
  );
    logic [7:0] c;
    c = ERR_NONE;
    if (ld && in_rng)        c = ERR_LD_STACK;
    else if (st && in_rng)   c = ERR_ST_STACK;
    else if (push && full)   c = ERR_PUSH_FULL;
    else if (pop && empty)   c = ERR_POP_EMPTY;
    else if (ret && empty)   c = ERR_RET_EMPTY;
    else if (call && full)   c = ERR_CALL_FULL;
    return c;
  endfunction

endpackage

// File: rtl/error_monitor_btn_sync_edge.sv
// Two-flop synchronizer for the active-low clear button
// plus a registered falling-edge detector.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic sync,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Synchronize raw button and keep last synchronized value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync = s2;
  assign fall = prev & ~s2;

endmodule

// File: rtl/error_monitor.sv
// Stack-region and stack-status violation monitor: latches the
// first error code, halts the core and counts discarded errors.
module error_monitor
  import error_monitor_pkg::*;
#(
  parameter logic [7:0] STACK_LO = 8'hF0,
  parameter logic [7:0] STACK_HI = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       ld_en,
  input  logic       st_en,
  input  logic       push_en,
  input  logic       pop_en,
  input  logic       call_en,
  input  logic       ret_en,
  input  logic       stk_full,
  input  logic       stk_empty,
  input  logic       clr_btn,
  output logic [7:0] ER_CDE,
  output logic       halt,
  output logic [3:0] lost_cnt
);

  state_e     state;
  state_e     state_nxt;
  logic [7:0] code_q;
  logic [7:0] code_nxt;
  logic       halt_q;
  logic       halt_nxt;
  logic [3:0] lost_q;
  logic [3:0] lost_nxt;
  logic       btn_sync;
  logic       clr_evt;
  logic       in_rng;
  logic [7:0] viol;

  btn_sync_edge u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (clr_btn),
    .sync (btn_sync),
    .fall (clr_evt)
  );

  // Widened compare keeps the bound checks honest at 8'h00/8'hFF.
  assign in_rng = ({1'b0, mem_addr} >= {1'b0, STACK_LO}) &&
                  ({1'b0, mem_addr} <= {1'b0, STACK_HI});

  assign viol = viol_code(in_rng, ld_en, st_en, push_en, pop_en,
                          call_en, ret_en, stk_full, stk_empty);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      code_q <= ERR_NONE;
      halt_q <= 1'b0;
      lost_q <= 4'd0;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      halt_q <= halt_nxt;
      lost_q <= lost_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    halt_nxt  = halt_q;
    lost_nxt  = lost_q;
    unique case (state)
      RUN: begin
        if (viol != ERR_NONE) begin
          state_nxt = FAULT;
          code_nxt  = viol;
          halt_nxt  = 1'b1;
        end
      end
      FAULT: begin
        if (clr_evt) begin
          state_nxt = RELEASE;
        end else if (viol != ERR_NONE && lost_q != LOST_MAX) begin
          lost_nxt = lost_q + 4'd1;
        end
      end
      RELEASE: begin
        if (btn_sync) begin
          state_nxt = RUN;
          code_nxt  = ERR_NONE;
          halt_nxt  = 1'b0;
          lost_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        code_nxt  = ERR_NONE;
        halt_nxt  = 1'b0;
        lost_nxt  = 4'd0;
      end
    endcase
  end

  assign ER_CDE   = code_q;
  assign halt     = halt_q;
  assign lost_cnt = lost_q;

endmodule

// File: tb/tb_error_monitor.sv
// Directed scoreboard bench for error_monitor.
// Expected outputs are queued with each stimulus step.
module tb_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic       ld_en, st_en;
  logic       push_en, pop_en, call_en, ret_en;
  logic       stk_full, stk_empty;
  logic       clr_btn;
  logic [7:0] ER_CDE;
  logic       halt;
  logic [3:0] lost_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [7:0] code;
    logic       halt;
    logic [3:0] lost;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  error_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .ld_en     (ld_en),
    .st_en     (st_en),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .clr_btn   (clr_btn),
    .ER_CDE    (ER_CDE),
    .halt      (halt),
    .lost_cnt  (lost_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] c,
                          input logic h, input logic [3:0] l);
    exp_t e;
    e.tag  = tag;
    e.code = c;
    e.halt = h;
    e.lost = l;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard empty got=0 want=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total += 3;
      assert (ER_CDE === e.code) else begin
        bad++;
        $error("FAIL %s ER_CDE got=%0h want=%0h", e.tag, ER_CDE, e.code);
      end
      assert (halt === e.halt) else begin
        bad++;
        $error("FAIL %s halt got=%0b want=%0b", e.tag, halt, e.halt);
      end
      assert (lost_cnt === e.lost) else begin
        bad++;
        $error("FAIL %s lost_cnt got=%0d want=%0d", e.tag, lost_cnt, e.lost);
      end
    end
  endtask

  task automatic step(input string tag, input logic [7:0] c,
                      input logic h, input logic [3:0] l);
    push_exp(tag, c, h, l);
    tick();
    check();
  endtask

  task automatic wait_clear(input string tag);
    push_exp(tag, 8'd0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (halt === 1'b0) break;
    end
    check();
  endtask

  task automatic idle();
    ld_en = 0; st_en = 0; push_en = 0; pop_en = 0;
    call_en = 0; ret_en = 0; stk_full = 0; stk_empty = 0;
    mem_addr = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    clr_btn = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    push_exp("reset", 8'd0, 1'b0, 4'd0);
    check();

    ld_en = 1; mem_addr = 8'hEF;
    step("ld_below", 8'd0, 1'b0, 4'd0);
    mem_addr = 8'hF0;
    step("ld_lo", 8'd1, 1'b1, 4'd0);

    ld_en = 0; st_en = 1; mem_addr = 8'hF5;
    step("lost1", 8'd1, 1'b1, 4'd1);
    step("lost2", 8'd1, 1'b1, 4'd2);
    step("lost3", 8'd1, 1'b1, 4'd3);

    idle();
    clr_btn = 0;
    step("press1", 8'd1, 1'b1, 4'd3);
    step("press2", 8'd1, 1'b1, 4'd3);
    pop_en = 1; stk_empty = 1;
    step("clr_viol", 8'd1, 1'b1, 4'd3);
    step("rel_ign1", 8'd1, 1'b1, 4'd3);
    step("rel_ign2", 8'd1, 1'b1, 4'd3);
    idle();
    clr_btn = 1;
    wait_clear("release1");

    clr_btn = 0;
    for (int i = 0; i < 5; i++) step("run_press", 8'd0, 1'b0, 4'd0);
    clr_btn = 1;
    for (int i = 0; i < 3; i++) step("run_rel", 8'd0, 1'b0, 4'd0);

    st_en = 1; mem_addr = 8'hFF; push_en = 1; stk_full = 1;
    step("st_hi_push", 8'd2, 1'b1, 4'd0);
    idle();

    pop_en = 1; stk_empty = 1;
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), 8'd2, 1'b1,
           (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    idle();
    clr_btn = 0;
    for (int i = 0; i < 5; i++) step("press_b", 8'd2, 1'b1, 4'd15);
    clr_btn = 1;
    wait_clear("release2");

    call_en = 1; stk_full = 1;
    step("call_full", 8'd6, 1'b1, 4'd0);
    idle();
    pop_en = 1; stk_empty = 1;
    step("pop_empty", 8'd6, 1'b1, 4'd1);
    idle();
    clr_btn = 0;
    step("press_c1", 8'd6, 1'b1, 4'd1);
    step("press_c2", 8'd6, 1'b1, 4'd1);
    ret_en = 1; stk_empty = 1;
    step("clr_ret", 8'd6, 1'b1, 4'd1);
    step("rel_ret", 8'd6, 1'b1, 4'd1);
    idle();

    rst = 1; call_en = 1; stk_full = 1;
    step("rst_rel", 8'd0, 1'b0, 4'd0);
    rst = 0;
    idle();
    clr_btn = 1;
    for (int i = 0; i < 3; i++) step("post_rst", 8'd0, 1'b0, 4'd0);

    push_en = 1; pop_en = 1; ld_en = 1; mem_addr = 8'h00;
    step("no_viol", 8'd0, 1'b0, 4'd0);
    idle();
    st_en = 1; mem_addr = 8'hEF;
    pop_en = 1; ret_en = 1; call_en = 1;
    stk_empty = 1; stk_full = 1;
    step("multi4", 8'd4, 1'b1, 4'd0);
    rst = 1;
    step("rst_viol", 8'd0, 1'b0, 4'd0);
    rst = 0;
    idle();
    ld_en = 1; mem_addr = 8'hFF;
    step("ld_hi", 8'd1, 1'b1, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/error_monitor.md
ERROR_MONITOR -- requirements
Module: error_monitor

Interface
REQ-001 Parameter STACK_LO, default 8'hF0, lowest data address reserved for the stack.
REQ-002 Parameter STACK_HI, default 8'hFF, highest data address reserved for the stack.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  input  8  data address of the current load/store.
REQ-006 ld_en / st_en  input  1 each  load / store executing this cycle.
REQ-007 push_en / pop_en / call_en / ret_en  input  1 each  stack operation executing this cycle.
REQ-008 stk_full / stk_empty  input  1 each  stack status flags, valid in the same cycle.
REQ-009 clr_btn  input  1  raw, asynchronous, active-low error-clear push button.
REQ-010 ER_CDE  output  8  registered latched error code, feeds the display handler.
REQ-011 halt  output  1  registered; stalls the processor while an error is held.
REQ-012 lost_cnt  output  4  registered saturating count of violations discarded while an error was held.

Function
REQ-013 Violation codes SHALL be: 1 load with STACK_LO<=mem_addr<=STACK_HI; 2 store in that range; 3 push_en&stk_full; 4 pop_en&stk_empty; 5 ret_en&stk_empty; 6 call_en&stk_full.
REQ-014 Range compare SHALL be unsigned and inclusive at both bounds.
REQ-015 When several violations occur in one cycle, the lowest code SHALL win; the others SHALL NOT be counted.
REQ-016 clr_btn SHALL pass through a two-flop synchronizer; a clear event is a registered 1-to-0 transition of the synchronized signal.
REQ-017 The FSM SHALL have states RUN, FAULT, RELEASE.
REQ-018 RUN: ER_CDE=0, halt=0; a violation in cycle N SHALL move to FAULT with ER_CDE=code and halt=1 visible in cycle N+1.
REQ-019 FAULT: ER_CDE and halt SHALL hold; each further violating cycle SHALL increment lost_cnt by one, saturating at 15.
REQ-020 FAULT: a clear event SHALL move to RELEASE; ER_CDE and halt SHALL hold.
REQ-021 RELEASE: SHALL move to RUN one cycle after the synchronized button reads 1; on that transition, ER_CDE, halt, and lost_cnt SHALL clear.
REQ-022 RELEASE: violations SHALL be ignored and not counted.
REQ-023 When a violation and a clear event coincide in FAULT, the clear SHALL take effect and the violation SHALL NOT be counted.
REQ-024 A clear event in RUN SHALL have no effect.
REQ-025 ER_CDE[7:3] SHALL always be 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force state RUN, ER_CDE=0, halt=0, lost_cnt=0, and both synchronizer flops and the edge register to 1, regardless of current state.
REQ-027 rst SHALL take priority over every other input, including violations in the same cycle.

Structure
REQ-028 Error code constants (ERR_NONE..ERR_CALL_FULL) and the FSM state encodings SHALL reside in a shared package, also used by the display handler.
REQ-029 The synchronizer and falling-edge detector SHALL be one sub-module, btn_sync_edge.

Verification
REQ-030 Reset, then ld_en=1, mem_addr=8'hEF -> ER_CDE=0, halt=0; mem_addr=8'hF0 -> ER_CDE=1, halt=1 the next cycle.
REQ-031 st_en with addr 8'hFF and push_en with stk_full in the same cycle -> ER_CDE=2, lost_cnt=0.
REQ-032 In FAULT, 20 cycles of pop_en with stk_empty -> lost_cnt=15, ER_CDE unchanged.
REQ-033 Press clr_btn for 5 cycles, then release -> ER_CDE=0, halt=0, lost_cnt=0 within 4 cycles of release; violations during the press are ignored.
REQ-034 rst asserted while in RELEASE, with call_en&stk_full in the same cycle -> RUN, ER_CDE=0 the next cycle.
REQ-035 ret_en&stk_empty in the same cycle as a clear event in FAULT -> RELEASE, lost_cnt unchanged.
